operand_fetch_ctrl: RTL

//  Sequences operand fetch for the 16-bit CPU datapath. Op1 and Op2 share one single-read-port register bank.

---
 rtl/operand_fetch_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/operand_fetch_ctrl.sv
// Operand fetch sequencer: reads Op1/Op2 through one shared register-bank read port,
// strobes the operand registers as bank data arrives, then offers the pair to the ALU.
module operand_fetch_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 16,
    parameter int RB_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_op1_addr,
    input  logic [ADDR_W-1:0] req_op2_addr,
    input  logic              req_op2_imm,
    input  logic [DATA_W-1:0] req_imm,
    output logic              rb_rd_en,
    output logic [ADDR_W-1:0] rb_rd_addr,
    output logic              Op1_load,
    output logic              Op2_load,
    output logic              Op2_src_imm,
    output logic [DATA_W-1:0] Op2_imm,
    output logic              ops_valid,
    input  logic              ops_ready,
    input  logic              flush,
    output logic              busy,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {IDLE, ISSUE1, ISSUE2, DRAIN, VALID} state_e;
    typedef enum logic [1:0] {TAG_NONE, TAG_OP1, TAG_OP2, TAG_BOTH} tag_e;

    state_e              state, state_nxt;
    tag_e                tag_pipe [RB_RD_LAT];
    tag_e                tag_push;
    tag_e                tag_exit;
    logic                pending;
    logic                accept;
    logic                imm_q;
    logic                same_q;
    logic [ADDR_W-1:0]   op2_addr_q;

    // Handshake: a request transfers on an edge where req_valid and req_ready are both high;
    // operands transfer on an edge where ops_valid and ops_ready are both high. flush overrides both.
    assign accept    = req_valid && (state == IDLE) && !flush;
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign ops_valid = (state == VALID);
    assign state_dbg = state;
    assign tag_exit  = tag_pipe[RB_RD_LAT-1];

    // Tags still travelling toward the exit stage (the exit stage itself strobes this cycle).
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < RB_RD_LAT - 1; i++) begin
            if (tag_pipe[i] != TAG_NONE) pending = 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        tag_push    = TAG_NONE;
        rb_rd_en    = 1'b0;
        Op2_src_imm = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) state_nxt = ISSUE1;
            end
            ISSUE1: begin
                rb_rd_en = 1'b1;
                if (imm_q) begin
                    tag_push    = TAG_OP1;
                    Op2_src_imm = 1'b1;
                    state_nxt   = DRAIN;
                end else if (same_q) begin
                    tag_push  = TAG_BOTH;
                    state_nxt = DRAIN;
                end else begin
                    tag_push  = TAG_OP1;
                    state_nxt = ISSUE2;
                end
            end
            ISSUE2: begin
                rb_rd_en  = 1'b1;
                tag_push  = TAG_OP2;
                state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!pending) state_nxt = VALID;
            end
            VALID: begin
                if (ops_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // An aborted request must not disturb the operand registers, even in the flush cycle.
    assign Op1_load = !flush && ((tag_exit == TAG_OP1) || (tag_exit == TAG_BOTH));
    assign Op2_load = !flush && ((tag_exit == TAG_OP2) || (tag_exit == TAG_BOTH) || Op2_src_imm);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            for (int i = 0; i < RB_RD_LAT; i++) tag_pipe[i] <= TAG_NONE;
        end else begin
            state <= state_nxt;
            if (flush) begin
                for (int i = 0; i < RB_RD_LAT; i++) tag_pipe[i] <= TAG_NONE;
            end else begin
                tag_pipe[0] <= tag_push;
                for (int i = 1; i < RB_RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // rb_rd_addr is preloaded one edge ahead of each issue state so it is stable while issuing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_rd_addr <= '0;
            op2_addr_q <= '0;
            imm_q      <= 1'b0;
            same_q     <= 1'b0;
            Op2_imm    <= '0;
        end else if (accept) begin
            rb_rd_addr <= req_op1_addr;
            op2_addr_q <= req_op2_addr;
            imm_q      <= req_op2_imm;
            same_q     <= (req_op1_addr == req_op2_addr);
            Op2_imm    <= req_imm;
        end else if (state == ISSUE1 && state_nxt == ISSUE2) begin
            rb_rd_addr <= op2_addr_q;
        end
    end

endmodule
